piso_tx: RTL and testbench

Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiver is the team's right-shifting SIPO shifter, in which the serial bit enters at the MSB.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word LSB-first, one bit per clk, with a frame qualifier.
- After WIDTH frame-qualified edges, a receiver clocked on the same clk holds the word intact.
- Supports gapless back-to-back words.

---
 rtl/piso_tx_if.sv | 30 +++
 rtl/piso_tx.sv | 96 +++++++++
 tb/tb_piso_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for the PISO transmitter.
// The master side presents words; the slave side (the transmitter) serialises them.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             data_out;
  logic             frame;
  logic             done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  data_out,
    input  frame,
    input  done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output data_out,
    output frame,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter.
// A word accepted on the valid/ready handshake is sent LSB-first, one bit per
// clock, qualified by frame. A receiver that shifts right (new bit entering at
// the MSB) on every frame-qualified edge ends up holding the original word.
// A new word may be accepted in the last bit cycle, giving gapless streaming.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        clr,
  piso_tx_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]  r_cnt;
  logic           r_frame;
  logic           r_done;

  logic           w_last;
  logic           w_ready;
  logic           w_accept;

  // The last bit of a word is on the line when the counter reaches WIDTH-1;
  // that cycle doubles as the slot for accepting the follow-on word.
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign w_ready  = (r_state == IDLE) || w_last;
  assign w_accept = bus.load && w_ready;

  // Transmit FSM: load on accept, shift while framing, pulse done after the last bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_shreg <= bus.data_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_frame <= 1'b1;
          end else begin
            r_frame <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Final bit leaves the line at this edge.
            r_done <= 1'b1;
            if (w_accept) begin
              // Gapless reload: frame stays high into bit 0 of the next word.
              r_shreg <= bus.data_in;
              r_cnt   <= '0;
              r_frame <= 1'b1;
            end else begin
              // Counter returns to 0 so it never holds a value above WIDTH-1.
              r_shreg <= r_shreg >> 1;
              r_cnt   <= '0;
              r_state <= IDLE;
              r_frame <= 1'b0;
            end
          end else begin
            r_done  <= 1'b0;
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Serial line is gated by frame and driven from registers only.
  assign bus.data_out = r_frame ? r_shreg[0] : 1'b0;
  assign bus.frame    = r_frame;
  assign bus.done     = r_done;
  assign bus.ready    = w_ready;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an 8-bit and a 4-bit instance, each with a right-shifting
// loopback receiver, checked every cycle against a bit-queue reference model.
module tb_piso_tx;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(8)) bus8 ();
  piso_tx_if #(.WIDTH(4)) bus4 ();

  piso_tx #(.WIDTH(8)) u_dut8 (.clk(clk), .clr(clr), .bus(bus8));
  piso_tx #(.WIDTH(4)) u_dut4 (.clk(clk), .clr(clr), .bus(bus4));

  // Loopback receivers: shift right with the serial bit entering at the MSB,
  // clocked only on frame-qualified edges.
  logic [7:0] rx8;
  logic [3:0] rx4;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx8 <= '0;
      rx4 <= '0;
    end else begin
      if (bus8.frame) rx8 <= {bus8.data_out, rx8[7:1]};
      if (bus4.frame) rx4 <= {bus4.data_out, rx4[3:1]};
    end
  end

  // Reference model: queue of bits still to appear on the line (head = the
  // bit on the line this cycle) plus queue of words awaiting their done pulse.
  bit         q8[$];
  bit         q4[$];
  logic [7:0] w8q[$];
  logic [3:0] w4q[$];
  logic       exp_done8;
  logic       exp_done4;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q8.delete();
    q4.delete();
    w8q.delete();
    w4q.delete();
    exp_done8 = 1'b0;
    exp_done4 = 1'b0;
  endtask

  task automatic check_all();
    logic [7:0] w8;
    logic [3:0] w4;
    chk("frame8", 32'(bus8.frame), 32'(q8.size() > 0));
    chk("dout8",  32'(bus8.data_out), 32'((q8.size() > 0) ? q8[0] : 1'b0));
    chk("ready8", 32'(bus8.ready), 32'(q8.size() <= 1));
    chk("done8",  32'(bus8.done), 32'(exp_done8));
    chk("frame4", 32'(bus4.frame), 32'(q4.size() > 0));
    chk("dout4",  32'(bus4.data_out), 32'((q4.size() > 0) ? q4[0] : 1'b0));
    chk("ready4", 32'(bus4.ready), 32'(q4.size() <= 1));
    chk("done4",  32'(bus4.done), 32'(exp_done4));
    if (exp_done8 && w8q.size() > 0) begin
      w8 = w8q.pop_front();
      chk("rx8", 32'(rx8), 32'(w8));
      $display("word8 %02h received %02h", w8, rx8);
    end
    if (exp_done4 && w4q.size() > 0) begin
      w4 = w4q.pop_front();
      chk("rx4", 32'(rx4), 32'(w4));
      $display("word4 %01h received %01h", w4, rx4);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    bit acc8, acc4;
    @(posedge clk);
    acc8      = bus8.load && (q8.size() <= 1);
    acc4      = bus4.load && (q4.size() <= 1);
    exp_done8 = (q8.size() == 1);
    exp_done4 = (q4.size() == 1);
    if (q8.size() > 0) void'(q8.pop_front());
    if (q4.size() > 0) void'(q4.pop_front());
    if (acc8) begin
      for (int i = 0; i < 8; i++) q8.push_back(bus8.data_in[i]);
      w8q.push_back(bus8.data_in);
    end
    if (acc4) begin
      for (int i = 0; i < 4; i++) q4.push_back(bus4.data_in[i]);
      w4q.push_back(bus4.data_in);
    end
    #1;
    check_all();
  endtask

  // Pulse load for one cycle with a word, then scramble data_in while it shifts.
  task automatic send8(input logic [7:0] word);
    bus8.load    = 1'b1;
    bus8.data_in = word;
    step();
    bus8.load    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.data_in = 8'($urandom);
      step();
    end
  endtask

  initial begin
    logic [7:0] words[5];
    words = '{8'h3C, 8'h00, 8'hFF, 8'h80, 8'h01};

    clr          = 1'b1;
    bus8.load    = 1'b0;
    bus8.data_in = '0;
    bus4.load    = 1'b0;
    bus4.data_in = '0;
    model_clear();
    #12;
    check_all();
    clr = 1'b0;
    step();

    // Single word A5 with explicit bit sequence.
    send8(8'hA5);
    step();

    // Loopback of several boundary patterns.
    foreach (words[i]) send8(words[i]);

    // load held high: A5 then 3C presented at the last bit cycle.
    bus8.load    = 1'b1;
    bus8.data_in = 8'hA5;
    step();
    for (int i = 0; i < 7; i++) step();
    bus8.data_in = 8'h3C;
    step();
    chk("gapless_frame", 32'(bus8.frame), 32'd1);
    chk("gapless_done",  32'(bus8.done), 32'd1);
    bus8.load = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Load during a word is ignored.
    bus8.load    = 1'b1;
    bus8.data_in = 8'hF0;
    step();
    bus8.load = 1'b0;
    step();
    step();
    bus8.load    = 1'b1;
    bus8.data_in = 8'h0F;
    step();
    bus8.load = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous clear during bit 4 of FF.
    bus8.load    = 1'b1;
    bus8.data_in = 8'hFF;
    step();
    bus8.load = 1'b0;
    step();
    step();
    step();
    #2;
    clr = 1'b1;
    #1;
    model_clear();
    chk("clr_frame", 32'(bus8.frame), 32'd0);
    chk("clr_dout",  32'(bus8.data_out), 32'd0);
    chk("clr_done",  32'(bus8.done), 32'd0);
    chk("clr_ready", 32'(bus8.ready), 32'd1);
    #1;
    clr = 1'b0;
    step();
    step();
    send8(8'h55);
    step();

    // 4-bit instance with 1001.
    bus4.load    = 1'b1;
    bus4.data_in = 4'b1001;
    step();
    bus4.load = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random traffic on both instances, data_in changing every cycle.
    for (int i = 0; i < 300; i++) begin
      bus8.load    = ($urandom_range(0, 2) != 0);
      bus8.data_in = 8'($urandom);
      bus4.load    = ($urandom_range(0, 1) != 0);
      bus4.data_in = 4'($urandom);
      step();
    end
    bus8.load = 1'b0;
    bus4.load = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
